// File: rtl/sev_seg_display_ctrl_if.sv
// Bus-side handshake between register logic and the seven-segment controller.
// The master loads values; the slave reports conversion status.
interface sev_seg_display_ctrl_if #(
    parameter int unsigned NUM_DIGITS = 6
) ();
    logic [4*NUM_DIGITS-1:0] value;
    logic                    load;
    logic                    dec_mode;
    logic                    busy;
    logic                    done;
    logic                    overflow;

    modport master (output value, load, dec_mode, input busy, done, overflow);
    modport slave  (input value, load, dec_mode, output busy, done, overflow);
endinterface

// File: rtl/sev_seg_display_ctrl.sv
// Multi-digit seven-segment driver: hex or double-dabble decimal display with
// leading-zero blanking, overflow dashes, blink and PWM brightness.
module sev_seg_display_ctrl #(
    parameter int unsigned NUM_DIGITS = 6,
    parameter bit          ACTIVE_LOW = 1'b1,
    parameter int unsigned PWM_BITS   = 4,
    parameter int unsigned BLINK_DIV  = 25000000
) (
    input  logic                    clk,
    input  logic                    reset,
    sev_seg_display_ctrl_if.slave   bus,
    input  logic                    blank_lz,
    input  logic                    blink_en,
    input  logic [PWM_BITS-1:0]     brightness,
    output logic [7*NUM_DIGITS-1:0] segs
);
    localparam int unsigned DW     = 4 * NUM_DIGITS;
    localparam int unsigned BW     = 4 * (NUM_DIGITS + 2);
    localparam int unsigned CntW   = (DW > 1) ? $clog2(DW) : 1;
    localparam int unsigned BlinkW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    localparam logic StIdle = 1'b0;
    localparam logic StConv = 1'b1;

    logic                    state_q;
    logic                    done_q;
    logic                    overflow_q;
    logic [DW-1:0]           digit_q;
    logic [DW-1:0]           shift_q;
    logic [BW-1:0]           bcd_q;
    logic [CntW-1:0]         cnt_q;
    logic [PWM_BITS-1:0]     pwm_q;
    logic [BlinkW-1:0]       blink_cnt_q;
    logic                    blink_on_q;

    logic [BW-1:0]           bcd_adj;
    logic [BW:0]             bcd_shift;
    logic [7*NUM_DIGITS-1:0] seg_al;
    logic [7*NUM_DIGITS-1:0] segs_d;
    logic [3:0]              nib;
    logic                    lead;
    logic                    lit;

    function automatic logic [6:0] glyph(input logic [3:0] d);
        case (d)
            4'h0: glyph = 7'h40;
            4'h1: glyph = 7'h79;
            4'h2: glyph = 7'h24;
            4'h3: glyph = 7'h30;
            4'h4: glyph = 7'h19;
            4'h5: glyph = 7'h12;
            4'h6: glyph = 7'h02;
            4'h7: glyph = 7'h78;
            4'h8: glyph = 7'h00;
            4'h9: glyph = 7'h10;
            4'hA: glyph = 7'h08;
            4'hB: glyph = 7'h03;
            4'hC: glyph = 7'h46;
            4'hD: glyph = 7'h21;
            4'hE: glyph = 7'h06;
            default: glyph = 7'h0E;
        endcase
    endfunction

    // Double-dabble step: correct digits >= 5, then shift in the next binary MSB.
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < NUM_DIGITS + 2; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
        end
        bcd_shift = {bcd_adj, shift_q[DW-1]};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            done_q     <= 1'b0;
            overflow_q <= 1'b0;
            digit_q    <= '0;
            shift_q    <= '0;
            bcd_q      <= '0;
            cnt_q      <= '0;
        end else begin
            done_q <= 1'b0;
            if (state_q == StIdle) begin
                if (bus.load) begin
                    if (bus.dec_mode) begin
                        shift_q <= bus.value;
                        bcd_q   <= '0;
                        cnt_q   <= '0;
                        state_q <= StConv;
                    end else begin
                        digit_q    <= bus.value;
                        overflow_q <= 1'b0;
                        done_q     <= 1'b1;
                    end
                end
            end else begin
                shift_q <= {shift_q[DW-2:0], 1'b0};
                bcd_q   <= bcd_shift[BW-1:0];
                cnt_q   <= cnt_q + CntW'(1);
                if (cnt_q == CntW'(DW - 1)) begin
                    digit_q    <= bcd_shift[DW-1:0];
                    overflow_q <= |bcd_shift[BW:DW];
                    done_q     <= 1'b1;
                    state_q    <= StIdle;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pwm_q       <= '0;
            blink_cnt_q <= '0;
            blink_on_q  <= 1'b1;
        end else begin
            pwm_q <= pwm_q + PWM_BITS'(1);
            if (blink_cnt_q == BlinkW'(BLINK_DIV - 1)) begin
                blink_cnt_q <= '0;
                blink_on_q  <= ~blink_on_q;
            end else begin
                blink_cnt_q <= blink_cnt_q + BlinkW'(1);
            end
        end
    end

    // Patterns are built active-low and inverted at the end if needed.
    always_comb begin
        seg_al = '1;
        nib    = '0;
        lead   = 1'b1;
        lit    = !(blink_en && !blink_on_q) && ((&brightness) || (pwm_q < brightness));
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            nib = digit_q[4*i +: 4];
            if (nib != 4'd0) lead = 1'b0;
            if (overflow_q)                      seg_al[7*i +: 7] = 7'h3F;
            else if (blank_lz && lead && i != 0) seg_al[7*i +: 7] = 7'h7F;
            else                                 seg_al[7*i +: 7] = glyph(nib);
        end
        if (!lit) seg_al = '1;
        segs_d = ACTIVE_LOW ? seg_al : ~seg_al;
    end

    always_ff @(posedge clk) begin
        if (reset) segs <= ACTIVE_LOW ? '1 : '0;
        else       segs <= segs_d;
    end

    assign bus.busy     = (state_q == StConv);
    assign bus.done     = done_q;
    assign bus.overflow = overflow_q;
endmodule

// File: tb/tb_sev_seg_display_ctrl.sv
// Directed bench for sev_seg_display_ctrl: 6 digits, active-low, 4-bit PWM,
// 8-cycle blink half-period.
module tb_sev_seg_display_ctrl;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        blank_lz;
    logic        blink_en;
    logic [3:0]  brightness;
    logic [41:0] segs;

    int vectors = 0;
    int miscompares = 0;
    int n;
    int lit;

    localparam logic [41:0] Blank = 42'h3FF_FFFF_FFFF;

    always #5 clk = ~clk;

    sev_seg_display_ctrl_if #(.NUM_DIGITS(6)) bus ();

    sev_seg_display_ctrl #(
        .NUM_DIGITS(6),
        .ACTIVE_LOW(1'b1),
        .PWM_BITS  (4),
        .BLINK_DIV (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .blank_lz  (blank_lz),
        .blink_en  (blink_en),
        .brightness(brightness),
        .segs      (segs)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_idle(output int cycles);
        cycles = 0;
        while (bus.busy && cycles < 100) begin
            cycles++;
            tick();
        end
    endtask

    task automatic count_lit(input int len, output int cnt);
        cnt = 0;
        for (int i = 0; i < len; i++) begin
            if (segs !== Blank) cnt++;
            tick();
        end
    endtask

    initial begin
        bus.value    = '0;
        bus.load     = 1'b0;
        bus.dec_mode = 1'b0;
        blank_lz     = 1'b0;
        blink_en     = 1'b0;
        brightness   = 4'hF;
        tick();
        tick();
        check("reset_segs", segs, Blank);
        check("reset_busy", bus.busy, 1'b0);
        check("reset_done", bus.done, 1'b0);
        check("reset_ovf", bus.overflow, 1'b0);
        reset = 1'b0;

        // Hex load, then a second load in the done cycle.
        bus.value = 24'h12AB3F;
        bus.load  = 1'b1;
        tick();
        check("hex_done", bus.done, 1'b1);
        bus.value = 24'h654321;
        tick();
        bus.load = 1'b0;
        check("hex_segs", segs, {7'h79, 7'h24, 7'h08, 7'h03, 7'h30, 7'h0E});
        check("hex2_done", bus.done, 1'b1);
        tick();
        check("hex2_segs", segs, {7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79});
        check("hex2_done_end", bus.done, 1'b0);

        // Decimal 123456 with an ignored load mid-conversion.
        bus.value    = 24'd123456;
        bus.dec_mode = 1'b1;
        bus.load     = 1'b1;
        tick();
        bus.load = 1'b0;
        n = 0;
        while (bus.busy && n < 100) begin
            n++;
            if (n == 5) begin
                bus.value    = 24'hFFFFFF;
                bus.dec_mode = 1'b0;
                bus.load     = 1'b1;
            end
            tick();
            bus.load = 1'b0;
        end
        check("dec_busy_cycles", n, 24);
        check("dec_done", bus.done, 1'b1);
        check("dec_ovf", bus.overflow, 1'b0);
        tick();
        check("dec_segs", segs, {7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02});

        // Decimal overflow, then decimal zero with blanking.
        bus.value    = 24'd1000000;
        bus.dec_mode = 1'b1;
        bus.load     = 1'b1;
        tick();
        bus.load = 1'b0;
        wait_idle(n);
        check("ovf_cycles", n, 24);
        check("ovf_flag", bus.overflow, 1'b1);
        tick();
        check("ovf_segs", segs, {6{7'h3F}});
        blank_lz  = 1'b1;
        bus.value = 24'd0;
        bus.load  = 1'b1;
        tick();
        bus.load = 1'b0;
        wait_idle(n);
        check("zero_ovf", bus.overflow, 1'b0);
        tick();
        check("zero_segs", segs, {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40});

        // Hex leading-zero blanking and its release.
        bus.value    = 24'h000030;
        bus.dec_mode = 1'b0;
        bus.load     = 1'b1;
        tick();
        bus.load = 1'b0;
        tick();
        check("lz_segs", segs, {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h30, 7'h40});
        blank_lz = 1'b0;
        tick();
        check("nolz_segs", segs, {7'h40, 7'h40, 7'h40, 7'h40, 7'h30, 7'h40});

        // PWM duty.
        brightness = 4'd4;
        tick();
        count_lit(16, lit);
        check("pwm4_lit", lit, 4);
        brightness = 4'd0;
        tick();
        count_lit(16, lit);
        check("pwm0_lit", lit, 0);
        brightness = 4'hF;
        tick();
        count_lit(16, lit);
        check("pwmF_lit", lit, 16);

        // Blink at 8-cycle half-period.
        blink_en = 1'b1;
        tick();
        count_lit(16, lit);
        check("blink16_lit", lit, 8);
        count_lit(32, lit);
        check("blink32_lit", lit, 16);
        blink_en = 1'b0;

        // Reset during a decimal conversion.
        bus.value    = 24'd123456;
        bus.dec_mode = 1'b1;
        bus.load     = 1'b1;
        tick();
        bus.load = 1'b0;
        tick();
        tick();
        check("abort_busy_before", bus.busy, 1'b1);
        reset = 1'b1;
        tick();
        check("abort_busy", bus.busy, 1'b0);
        check("abort_done", bus.done, 1'b0);
        check("abort_segs", segs, Blank);
        reset = 1'b0;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.done) n++;
            tick();
        end
        check("abort_no_done", n, 0);
        check("abort_idle", bus.busy, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/sev_seg_display_ctrl.md
Name: sev_seg_display_ctrl

Overview:
Parametrised multi-digit seven-segment driver for the board HEX displays. It latches a value on a load strobe and shows it in one of two modes:
- hex mode: each nibble drives one digit;
- decimal mode: an iterative double-dabble binary-to-BCD converter runs first.
On top of the digit encoding it adds leading-zero blanking, decimal overflow indication, blink, and PWM brightness control. It sits between the bus/register logic and the HEX pins.

Parameters:
NUM_DIGITS, 6, number of digits driven; legal range 1..8.
ACTIVE_LOW, 1, 1 = segment lit by driving 0; 0 = lit by driving 1.
PWM_BITS, 4, width of the brightness value and of the PWM counter.
BLINK_DIV, 25000000, clock cycles per blink half-period; must be >= 1.

Ports:
clk  in  1  system clock.
reset  in  1  synchronous, active-high reset.
value  in  4*NUM_DIGITS  value to display; unsigned binary in decimal mode.
load  in  1  one-cycle strobe that samples value and dec_mode.
dec_mode  in  1  0 = hex, 1 = decimal; sampled with load.
blank_lz  in  1  1 = blank leading zero digits; level-sensitive.
blink_en  in  1  1 = whole display blinks; level-sensitive.
brightness  in  PWM_BITS  duty value; all-ones = 100 %.
busy  out  1  decimal conversion in progress.
done  out  1  one-cycle pulse when new digits are latched.
overflow  out  1  last decimal value exceeded 10^NUM_DIGITS-1.
segs  out  7*NUM_DIGITS  digit i occupies bits [7i+6:7i]; bit0 = seg a … bit6 = seg g.

Behaviour:
- Clock and reset: single clock domain clk; reset is synchronous and active-high.
- Reset values: busy=0, done=0, overflow=0, all segs blank (all 1 when ACTIVE_LOW), digit register cleared, PWM counter=0, blink counter=0, blink phase=on. Reset mid-conversion aborts the conversion; no done pulse is produced.
- Load acceptance: load is accepted only when busy=0. A load while busy=1 is ignored and does not affect the running conversion.
- Hex mode (load in cycle k):
  - at the edge ending cycle k, digit register ← value and overflow ← 0;
  - done=1 in cycle k+1;
  - segs show the new value in cycle k+2.
- Decimal mode (load in cycle k):
  - shift register ← value; BCD register (NUM_DIGITS+2 digits) ← 0; busy=1 from cycle k+1;
  - each busy cycle: add 3 to every BCD digit >= 5, then shift left by 1, taking the binary MSB in;
  - exactly 4*NUM_DIGITS shifts, so busy stays high for 4*NUM_DIGITS cycles;
  - the last shift also writes the low NUM_DIGITS BCD digits to the digit register;
  - overflow ← (either upper BCD digit nonzero);
  - busy=0 and done=1 in cycle k+4*NUM_DIGITS+1; segs update one cycle later.
- Encoding: values 0-F use the standard hex glyphs (b and d in lower case). Patterns below are for ACTIVE_LOW=1; all outputs are inverted when ACTIVE_LOW=0.
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E.
  - overflow=1: every digit shows "-" (7'h3F), regardless of blank_lz.
- Leading-zero blanking (blank_lz=1): every digit above the most significant nonzero digit is blank (7'h7F). Digit 0 is never blanked, so value 0 shows a single "0".
- Blink:
  - the blink counter counts 0..BLINK_DIV-1 and toggles the phase on wrap;
  - blink_en=1 with phase off: all digits blank;
  - blink_en=0: phase is ignored, but the counter keeps running.
- PWM:
  - the free-running PWM counter wraps at 2^PWM_BITS;
  - segments are enabled when counter < brightness, or when brightness is all-ones;
  - brightness=0 means the display is always blank.
- Output register: segs is registered. Changes in blank_lz, blink, brightness or PWM appear one cycle after the condition.
- Simultaneous events: reset has priority over load. A load in the same cycle that done pulses is accepted.

Test Plan:
1. Reset → segs=42'h3FF_FFFF_FFFF (all 7'h7F); busy=0, done=0, overflow=0.
2. Hex, NUM_DIGITS=6, brightness=F, value=24'h12AB3F, load → digits 5..0 = 79,24,08,03,30,0E in cycle k+2; done in cycle k+1.
3. Decimal, value=24'd123456, load → busy high exactly 24 cycles; done; digits 5..0 = 79,24,30,19,12,02; overflow=0. A second load pulsed mid-conversion is ignored.
4. Decimal, value=24'd1000000 → overflow=1; all six digits = 3F. Then decimal value=0 with blank_lz=1 → overflow=0; digits 5..1 = 7F, digit 0 = 40.
5. Hex, value=24'h000030, blank_lz=1 → digits 5..2 = 7F, digit 1 = 30, digit 0 = 40. Toggle blank_lz=0 → digits 5..2 = 40 one cycle later.
6. PWM_BITS=4, brightness=4 → segs lit 4 of every 16 cycles. BLINK_DIV=8, blink_en=1 → alternating 8 cycles lit / 8 blank. Reset asserted mid-decimal-conversion → busy=0 next cycle, no done, segs blank.
